// File: rtl/tx_dispatch_arbiter.sv
// tx_dispatch_arbiter: round-robin transaction dispatcher with
// conflict retry/backoff, result timeout and batch boundary handshake.
module tx_dispatch_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int BATCH_SIZE = 8,
  parameter int MAX_RETRY  = 3,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*64-1:0]   req_id,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    fwd_valid,
  output logic [63:0]             fwd_id,
  output logic [1:0]              fwd_src,
  input  logic                    fwd_ready,
  input  logic                    res_valid,
  input  logic                    res_conflict,
  input  logic [63:0]             res_id,
  output logic                    done_valid,
  output logic [1:0]              done_src,
  output logic [1:0]              done_status,
  output logic                    batch_close,
  output logic [3:0]              batch_count,
  input  logic                    batch_ack
);

  localparam int RW = (MAX_RETRY < 1) ? 1
                    : $clog2(MAX_RETRY + 1);
  localparam int BW = RW + 2;
  localparam int TW = (TIMEOUT < 2) ? 1
                    : $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_CONF = 2'b01;
  localparam logic [1:0] ST_TMO  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_BACKOFF,
    S_CLOSE
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           last_q, last_d;
  logic [63:0]          id_q, id_d;
  logic [1:0]           src_q, src_d;
  logic [RW-1:0]        retry_q, retry_d;
  logic [BW-1:0]        bo_q, bo_d;
  logic [TW-1:0]        tmr_q, tmr_d;
  logic                 dv_q, dv_d;
  logic [1:0]           dst_q, dst_d;
  logic [3:0]           bcnt_q, bcnt_d;
  logic [NUM_REQ-1:0]   rdy_q, rdy_d;
  logic                 arm_q;

  logic                 gnt_ok;
  logic [1:0]           gnt_idx;
  logic                 match;
  logic [RW-1:0]        retry_nx;
  logic [3:0]           bcnt_nx;

  assign match    = res_valid && (res_id == id_q);
  assign retry_nx = retry_q + RW'(1);
  assign bcnt_nx  = bcnt_q + 4'd1;

  // Round-robin pick starting one past the last granted requester
  always_comb begin
    gnt_ok  = 1'b0;
    gnt_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!gnt_ok && req_valid[last_q + 2'(k)]) begin
        gnt_ok  = 1'b1;
        gnt_idx = last_q + 2'(k);
      end
    end
  end

  // Next-state and datapath updates for the dispatch FSM
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    src_d   = src_q;
    retry_d = retry_q;
    bo_d    = bo_q;
    tmr_d   = tmr_q;
    dv_d    = 1'b0;
    dst_d   = dst_q;
    bcnt_d  = bcnt_q;
    rdy_d   = '0;
    unique case (state_q)
      S_IDLE: begin
        if (arm_q && gnt_ok) begin
          id_d           = req_id[{gnt_idx, 6'd0} +: 64];
          src_d          = gnt_idx;
          rdy_d[gnt_idx] = 1'b1;
          last_d         = gnt_idx;
          retry_d        = '0;
          state_d        = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (fwd_ready) begin
          tmr_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        tmr_d = tmr_q + TW'(1);
        if (match && !res_conflict) begin
          dv_d   = 1'b1;
          dst_d  = ST_OK;
          bcnt_d = bcnt_nx;
          if (bcnt_nx == 4'(BATCH_SIZE)) begin
            state_d = S_CLOSE;
          end else begin
            state_d = S_IDLE;
          end
        end else if (match) begin
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_nx;
            bo_d    = {retry_nx, 2'b00};
            state_d = S_BACKOFF;
          end else begin
            dv_d    = 1'b1;
            dst_d   = ST_CONF;
            state_d = S_IDLE;
          end
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          dv_d    = 1'b1;
          dst_d   = ST_TMO;
          state_d = S_IDLE;
        end
      end
      S_BACKOFF: begin
        bo_d = bo_q - BW'(1);
        if (bo_q <= BW'(1)) begin
          state_d = S_ISSUE;
        end
      end
      S_CLOSE: begin
        if (batch_ack) begin
          bcnt_d  = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= 2'd3;
      id_q    <= '0;
      src_q   <= '0;
      retry_q <= '0;
      bo_q    <= '0;
      tmr_q   <= '0;
      dv_q    <= 1'b0;
      dst_q   <= '0;
      bcnt_q  <= '0;
      rdy_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      src_q   <= src_d;
      retry_q <= retry_d;
      bo_q    <= bo_d;
      tmr_q   <= tmr_d;
      dv_q    <= dv_d;
      dst_q   <= dst_d;
      bcnt_q  <= bcnt_d;
      rdy_q   <= rdy_d;
    end
  end

  // Hold off granting on the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_q <= 1'b0;
    end else begin
      arm_q <= 1'b1;
    end
  end

  assign req_ready   = rdy_q;
  assign fwd_valid   = (state_q == S_ISSUE);
  assign fwd_id      = id_q;
  assign fwd_src     = src_q;
  assign done_valid  = dv_q;
  assign done_src    = src_q;
  assign done_status = dst_q;
  assign batch_close = (state_q == S_CLOSE);
  assign batch_count = bcnt_q;

endmodule

// File: tb/tb_tx_dispatch_arbiter.sv
// tb_tx_dispatch_arbiter: table of directed transactions plus
// hand sequences for stall, stray batch_ack and mid-flight reset.
module tb_tx_dispatch_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [255:0] req_id;
  logic [3:0]   req_ready;
  logic         fwd_valid;
  logic [63:0]  fwd_id;
  logic [1:0]   fwd_src;
  logic         fwd_ready;
  logic         res_valid;
  logic         res_conflict;
  logic [63:0]  res_id;
  logic         done_valid;
  logic [1:0]   done_src;
  logic [1:0]   done_status;
  logic         batch_close;
  logic [3:0]   batch_count;
  logic         batch_ack;

  logic [63:0]  ids [4];
  int           n_chk = 0;
  int           n_pass = 0;
  int           exp_bcnt = 0;

  typedef struct {
    logic [3:0] mask;
    int         nconf;
    bit         to;
    bit         drop;
    logic [1:0] src;
    logic [1:0] st;
  } vec_t;

  vec_t vt [12];

  always #5 clk = ~clk;

  assign req_id = {ids[3], ids[2], ids[1], ids[0]};

  tx_dispatch_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_id       (req_id),
    .req_ready    (req_ready),
    .fwd_valid    (fwd_valid),
    .fwd_id       (fwd_id),
    .fwd_src      (fwd_src),
    .fwd_ready    (fwd_ready),
    .res_valid    (res_valid),
    .res_conflict (res_conflict),
    .res_id       (res_id),
    .done_valid   (done_valid),
    .done_src     (done_src),
    .done_status  (done_status),
    .batch_close  (batch_close),
    .batch_count  (batch_count),
    .batch_ack    (batch_ack)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h",
                  nm, act, exp);
  endtask

  task automatic wait_grant();
    int n;
    n = 0;
    while (req_ready == 4'd0 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_txn(input vec_t v,
                         input logic [3:0] nxt);
    int c;
    logic [63:0] id;
    id = ids[v.src];
    wait_grant();
    chk("grant", 64'(req_ready), 64'(4'd1 << v.src));
    chk("fwd_id", fwd_id, id);
    chk("fwd_src", 64'(fwd_src), 64'(v.src));
    chk("fwd_valid", 64'(fwd_valid), 64'd1);
    if (v.drop) req_valid = 4'd0;
    for (int a = 0; a < 5; a++) begin
      @(negedge clk);
      if (a == 0)
        chk("rdy_pulse", 64'(req_ready), 64'd0);
      if (v.to) begin
        c = 0;
        while (!done_valid && c < 300) begin
          res_valid = (c == 100);
          res_id = id + 64'd1;
          @(negedge clk);
          c++;
        end
        res_valid = 1'b0;
        chk("tmo_cycles", 64'(c), 64'd255);
        break;
      end
      res_valid = 1'b1;
      res_id = id;
      res_conflict = (a < v.nconf);
      @(negedge clk);
      res_valid = 1'b0;
      res_conflict = 1'b0;
      if (a >= v.nconf || a >= 3) break;
      c = 0;
      while (!fwd_valid && c < 40) begin
        @(negedge clk);
        c++;
      end
      chk("backoff", 64'(c), 64'(4 * (a + 1)));
      chk("retry_id", fwd_id, id);
    end
    req_valid = nxt;
    if (v.st == 2'b00) exp_bcnt++;
    chk("done_valid", 64'(done_valid), 64'd1);
    chk("done_status", 64'(done_status), 64'(v.st));
    chk("done_src", 64'(done_src), 64'(v.src));
    chk("batch_count", 64'(batch_count),
        64'(exp_bcnt));
    chk("batch_close", 64'(batch_close),
        64'(exp_bcnt == 8));
    @(negedge clk);
    chk("done_pulse", 64'(done_valid), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ids[0] = 64'h0123_4567_89AB_CDEF;
    ids[1] = 64'h0000_0000_0000_0001;
    ids[2] = 64'h0000_0000_0000_ABCD;
    ids[3] = 64'hFFFF_FFFF_FFFF_FFFF;

    vt[0]  = '{4'hF, 0, 1'b0, 1'b0, 2'd0, 2'd0};
    vt[1]  = '{4'hF, 0, 1'b0, 1'b0, 2'd1, 2'd0};
    vt[2]  = '{4'hF, 0, 1'b0, 1'b0, 2'd2, 2'd0};
    vt[3]  = '{4'hF, 0, 1'b0, 1'b0, 2'd3, 2'd0};
    vt[4]  = '{4'hF, 0, 1'b0, 1'b0, 2'd0, 2'd0};
    vt[5]  = '{4'h4, 3, 1'b0, 1'b1, 2'd2, 2'd0};
    vt[6]  = '{4'h4, 4, 1'b0, 1'b0, 2'd2, 2'd1};
    vt[7]  = '{4'hA, 0, 1'b0, 1'b0, 2'd3, 2'd0};
    vt[8]  = '{4'h3, 0, 1'b1, 1'b0, 2'd0, 2'd2};
    vt[9]  = '{4'h2, 0, 1'b0, 1'b0, 2'd1, 2'd0};
    vt[10] = '{4'hF, 0, 1'b0, 1'b0, 2'd2, 2'd0};
    vt[11] = '{4'h1, 1, 1'b0, 1'b0, 2'd0, 2'd0};

    rst_n = 1'b0;
    req_valid = 4'd0;
    fwd_ready = 1'b1;
    res_valid = 1'b0;
    res_conflict = 1'b0;
    res_id = 64'd0;
    batch_ack = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_fwd_valid", 64'(fwd_valid), 64'd0);
    chk("rst_fwd_id", fwd_id, 64'd0);
    chk("rst_fwd_src", 64'(fwd_src), 64'd0);
    chk("rst_done", 64'(done_valid), 64'd0);
    chk("rst_status", 64'(done_status), 64'd0);
    chk("rst_close", 64'(batch_close), 64'd0);
    chk("rst_count", 64'(batch_count), 64'd0);

    rst_n = 1'b1;
    req_valid = vt[0].mask;
    @(negedge clk);
    chk("first_edge", 64'(req_ready), 64'd0);

    for (int i = 0; i < 12; i++) begin
      run_txn(vt[i], (i < 11) ? vt[i+1].mask : 4'd0);
      if (exp_bcnt == 8) begin
        for (int k = 0; k < 5; k++) begin
          chk("close_hold",
              64'({batch_close, req_ready}),
              64'(5'b10000));
          @(negedge clk);
        end
        batch_ack = 1'b1;
        @(negedge clk);
        batch_ack = 1'b0;
        exp_bcnt = 0;
        chk("ack_count", 64'(batch_count), 64'd0);
        chk("ack_close", 64'(batch_close), 64'd0);
      end
    end

    batch_ack = 1'b1;
    repeat (2) @(negedge clk);
    chk("stray_ack_cnt", 64'(batch_count),
        64'(exp_bcnt));
    chk("stray_ack_close", 64'(batch_close), 64'd0);
    batch_ack = 1'b0;

    fwd_ready = 1'b0;
    req_valid = 4'b0100;
    wait_grant();
    chk("stall_grant", 64'(req_ready), 64'h4);
    req_valid = 4'd0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("stall_valid", 64'(fwd_valid), 64'd1);
      chk("stall_id", fwd_id, ids[2]);
    end
    fwd_ready = 1'b1;
    @(negedge clk);
    chk("stall_wait", 64'(fwd_valid), 64'd0);
    res_valid = 1'b1;
    res_id = ids[2];
    @(negedge clk);
    res_valid = 1'b0;
    exp_bcnt++;
    chk("stall_done", 64'(done_valid), 64'd1);
    chk("stall_status", 64'(done_status), 64'd0);
    chk("stall_src", 64'(done_src), 64'd2);
    chk("stall_count", 64'(batch_count),
        64'(exp_bcnt));

    req_valid = 4'b0100;
    wait_grant();
    chk("rr_grant", 64'(req_ready), 64'h4);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_ready", 64'(req_ready), 64'd0);
    chk("mid_fwd_valid", 64'(fwd_valid), 64'd0);
    chk("mid_fwd_id", fwd_id, 64'd0);
    chk("mid_fwd_src", 64'(fwd_src), 64'd0);
    chk("mid_done", 64'(done_valid), 64'd0);
    chk("mid_status", 64'(done_status), 64'd0);
    chk("mid_close", 64'(batch_close), 64'd0);
    chk("mid_count", 64'(batch_count), 64'd0);
    @(negedge clk);
    chk("mid_no_done", 64'(done_valid), 64'd0);
    req_valid = 4'hF;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_edge1", 64'(req_ready), 64'd0);
    chk("rel_no_done", 64'(done_valid), 64'd0);
    @(negedge clk);
    chk("rel_grant", 64'(req_ready), 64'h1);
    chk("rel_src", 64'(fwd_src), 64'd0);
    chk("rel_id", fwd_id, ids[0]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
